// File: rtl/mycpu_pkg.sv
// rtl/mycpu_pkg.sv - shared pipeline constants, history-entry layout and hazard helpers
//
// Purpose : common definitions for the hazard/forwarding controller.
//           Forward-select encodings, scoreboard history entry field
//           positions, the mult/div FSM state type and a register-match helper.
// Ports   : none (package)

package mycpu_pkg;

   localparam logic [1:0] FWD_REGFILE = 2'b00;
   localparam logic [1:0] FWD_EX      = 2'b01;
   localparam logic [1:0] FWD_MEM     = 2'b10;
   localparam logic [1:0] FWD_WB      = 2'b11;

   // History entry layout: {is_load, dest_reg[4:0]}
   localparam int HIST_LOAD_BIT = 5;
   localparam int HIST_REG_MSB  = 4;

   typedef enum logic {
      MD_IDLE = 1'b0,
      MD_BUSY = 1'b1
   } mdState_t;

   // True when a used source register is produced by this history entry.
   // Register 0 is hard-wired to zero, so it never creates a dependency.
   function automatic logic histHit(input logic [5:0] entry,
                                    input logic [4:0] srcReg,
                                    input logic       useSrc);
      return useSrc
          && (entry[HIST_REG_MSB:0] != 5'd0)
          && (entry[HIST_REG_MSB:0] == srcReg);
   endfunction

endpackage

// File: rtl/hazard_ctrl_fwd_sel.sv
// rtl/hazard_ctrl_fwd_sel.sv - priority match of one source register against the 3-deep history
//
// Purpose : selects the nearest producer of one source operand
//           (EX beats MEM beats WB) and flags an EX-stage hit for load-use.
// Ports   : idValid  in  ID holds a valid instruction
//           srcReg   in  5-bit source register
//           useSrc   in  instruction actually reads srcReg
//           hist1..3 in  history entries EX / MEM / WB
//           sel      out forward select (FWD_* encoding)
//           hitEx    out source matches the EX-stage entry

import mycpu_pkg::*;

module fwd_sel (
   input  logic       idValid,
   input  logic [4:0] srcReg,
   input  logic       useSrc,
   input  logic [5:0] hist1,
   input  logic [5:0] hist2,
   input  logic [5:0] hist3,
   output logic [1:0] sel,
   output logic       hitEx
);

   logic hit1;
   logic hit2;
   logic hit3;

   always_comb begin
      hit1 = histHit(hist1, srcReg, useSrc);
      hit2 = histHit(hist2, srcReg, useSrc);
      hit3 = histHit(hist3, srcReg, useSrc);
   end

   always_comb begin
      sel = FWD_REGFILE;
      if (idValid) begin
         if (hit1)      sel = FWD_EX;
         else if (hit2) sel = FWD_MEM;
         else if (hit3) sel = FWD_WB;
      end
   end

   assign hitEx = idValid & hit1;

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - decode-stage hazard, bubble and forwarding controller with mult/div busy FSM
//
// Purpose : derives stall / bubble / forwarding selects for the 5-stage
//           pipeline from the scoreboard history and tracks HI/LO occupancy.
// Config  : define HAZARD_PERF_CNT_EN to add stall-cause performance counters.
// Ports   : clk, rst             clock, synchronous active-high reset
//           id_valid             ID holds a valid instruction
//           id_rs, id_rt         source registers
//           id_use_rs, id_use_rt instruction reads rs / rt
//           id_is_muldiv         mult/multu/div/divu in ID
//           id_reads_hilo        mfhi/mflo in ID
//           flush                IF/ID flush
//           hist1/2/3            scoreboard entries EX / MEM / WB
//           stall                hold PC and IF/ID
//           bubble               inject NOP into EX
//           fwd_rs, fwd_rt       operand forward selects
//           muldiv_busy          HI/LO unit occupied
//           stall_load_cnt       load-use stall cycles   (HAZARD_PERF_CNT_EN)
//           stall_muldiv_cnt     mult/div stall cycles   (HAZARD_PERF_CNT_EN)

import mycpu_pkg::*;

module hazard_ctrl #(
   parameter int MULDIV_LAT = 4,
   parameter int CNT_W      = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             id_valid,
   input  logic [4:0]       id_rs,
   input  logic [4:0]       id_rt,
   input  logic             id_use_rs,
   input  logic             id_use_rt,
   input  logic             id_is_muldiv,
   input  logic             id_reads_hilo,
   input  logic             flush,
   input  logic [5:0]       hist1,
   input  logic [5:0]       hist2,
   input  logic [5:0]       hist3,
   output logic             stall,
   output logic             bubble,
   output logic [1:0]       fwd_rs,
   output logic [1:0]       fwd_rt,
   output logic             muldiv_busy
`ifdef HAZARD_PERF_CNT_EN
   ,
   output logic [CNT_W-1:0] stall_load_cnt,
   output logic [CNT_W-1:0] stall_muldiv_cnt
`endif
);

   generate
      if (MULDIV_LAT < 2 || MULDIV_LAT > 15 || CNT_W < 1) begin : gBadParam
         $error("hazard_ctrl: MULDIV_LAT must be 2..15 and CNT_W >= 1");
      end
   endgenerate

   localparam logic [3:0] CNT_RELOAD = 4'(MULDIV_LAT - 1);

   mdState_t   state;
   mdState_t   stateNext;
   logic [3:0] cnt;
   logic [3:0] cntNext;

   logic rsHitEx;
   logic rtHitEx;
   logic loadStall;
   logic mdStall;
   logic anyStall;
   logic accept;

   // ------------------------------------------------------------------
   // Forwarding selects, one matcher per operand
   // ------------------------------------------------------------------
   fwd_sel uFwdRs (
      .idValid (id_valid),
      .srcReg  (id_rs),
      .useSrc  (id_use_rs),
      .hist1   (hist1),
      .hist2   (hist2),
      .hist3   (hist3),
      .sel     (fwd_rs),
      .hitEx   (rsHitEx)
   );

   fwd_sel uFwdRt (
      .idValid (id_valid),
      .srcReg  (id_rt),
      .useSrc  (id_use_rt),
      .hist1   (hist1),
      .hist2   (hist2),
      .hist3   (hist3),
      .sel     (fwd_rt),
      .hitEx   (rtHitEx)
   );

   // A load in EX has no data yet; one bubble moves it to MEM where the
   // MEM forward path covers the consumer.
   always_comb begin
      loadStall = hist1[HIST_LOAD_BIT] & (rsHitEx | rtHitEx);
   end

   // ------------------------------------------------------------------
   // Mult/div FSM: state register
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= MD_IDLE;
         cnt   <= 4'd0;
      end else begin
         state <= stateNext;
         cnt   <= cntNext;
      end
   end

   // ------------------------------------------------------------------
   // Mult/div FSM: outputs and stall decision
   // ------------------------------------------------------------------
   always_comb begin
      muldiv_busy = (state == MD_BUSY);
      // On the final busy cycle (cnt==0) HI/LO is ready at the edge, so a
      // waiting consumer is released now rather than one cycle later.
      mdStall     = (state == MD_BUSY) && (cnt != 4'd0)
                 && id_valid && (id_is_muldiv || id_reads_hilo);
      anyStall    = loadStall | mdStall;
      stall       = anyStall & ~flush;
      bubble      = anyStall | flush;
      accept      = id_valid & id_is_muldiv & ~anyStall & ~flush;
   end

   // ------------------------------------------------------------------
   // Mult/div FSM: next state
   // ------------------------------------------------------------------
   always_comb begin
      stateNext = state;
      cntNext   = cnt;
      case (state)
         MD_IDLE: begin
            if (accept) begin
               stateNext = MD_BUSY;
               cntNext   = CNT_RELOAD;
            end
         end
         MD_BUSY: begin
            if (cnt == 4'd0) begin
               // Back-to-back: a queued op reloads on the completing edge.
               if (accept) begin
                  stateNext = MD_BUSY;
                  cntNext   = CNT_RELOAD;
               end else begin
                  stateNext = MD_IDLE;
               end
            end else begin
               cntNext = cnt - 4'd1;
            end
         end
         default: begin
            stateNext = MD_IDLE;
            cntNext   = 4'd0;
         end
      endcase
   end

`ifdef HAZARD_PERF_CNT_EN
   // Counts stall causes, independent of whether flush masked the stall.
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_load_cnt   <= '0;
         stall_muldiv_cnt <= '0;
      end else begin
         if (loadStall) stall_load_cnt   <= stall_load_cnt + 1'b1;
         if (mdStall)   stall_muldiv_cnt <= stall_muldiv_cnt + 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - self-checking bench for hazard_ctrl

module tb_hazard_ctrl;

   localparam int LAT   = 4;
   localparam int CNT_W = 32;

   logic       clk = 1'b0;
   logic       rst;
   logic       id_valid;
   logic [4:0] id_rs;
   logic [4:0] id_rt;
   logic       id_use_rs;
   logic       id_use_rt;
   logic       id_is_muldiv;
   logic       id_reads_hilo;
   logic       flush;
   logic [5:0] hist1;
   logic [5:0] hist2;
   logic [5:0] hist3;
   logic       stall;
   logic       bubble;
   logic [1:0] fwd_rs;
   logic [1:0] fwd_rt;
   logic       muldiv_busy;
`ifdef HAZARD_PERF_CNT_EN
   logic [CNT_W-1:0] stall_load_cnt;
   logic [CNT_W-1:0] stall_muldiv_cnt;
`endif

   int nVec = 0;
   int nMis = 0;

   always #5 clk = ~clk;

   hazard_ctrl #(.MULDIV_LAT(LAT), .CNT_W(CNT_W)) dut (
      .clk           (clk),
      .rst           (rst),
      .id_valid      (id_valid),
      .id_rs         (id_rs),
      .id_rt         (id_rt),
      .id_use_rs     (id_use_rs),
      .id_use_rt     (id_use_rt),
      .id_is_muldiv  (id_is_muldiv),
      .id_reads_hilo (id_reads_hilo),
      .flush         (flush),
      .hist1         (hist1),
      .hist2         (hist2),
      .hist3         (hist3),
      .stall         (stall),
      .bubble        (bubble),
      .fwd_rs        (fwd_rs),
      .fwd_rt        (fwd_rt),
      .muldiv_busy   (muldiv_busy)
`ifdef HAZARD_PERF_CNT_EN
      ,
      .stall_load_cnt   (stall_load_cnt),
      .stall_muldiv_cnt (stall_muldiv_cnt)
`endif
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nVec++;
      if (act !== exp) begin
         nMis++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // busyLeft = number of cycles (including this one) HI/LO stays occupied.
   int        busyLeft = 0;
   int        mLoadCnt = 0;
   int        mMdCnt   = 0;
   logic [1:0] expFwdRs;
   logic [1:0] expFwdRt;
   logic       expLoad;
   logic       expMd;
   logic       expStall;
   logic       expBubble;
   logic       expAccept;

   function automatic logic [1:0] mFwd(input logic v, input logic [4:0] s, input logic u,
                                       input logic [5:0] h1, input logic [5:0] h2,
                                       input logic [5:0] h3);
      logic [5:0] h [3];
      h[0] = h1; h[1] = h2; h[2] = h3;
      if (!v || !u || s == 5'd0) return 2'd0;
      for (int k = 0; k < 3; k++)
         if (h[k][4:0] == s) return 2'(k + 1);
      return 2'd0;
   endfunction

   always_comb begin
      expFwdRs  = mFwd(id_valid, id_rs, id_use_rs, hist1, hist2, hist3);
      expFwdRt  = mFwd(id_valid, id_rt, id_use_rt, hist1, hist2, hist3);
      expLoad   = hist1[5] && (expFwdRs == 2'd1 || expFwdRt == 2'd1);
      expMd     = (busyLeft > 1) && id_valid && (id_is_muldiv || id_reads_hilo);
      expStall  = (expLoad || expMd) && !flush;
      expBubble = expLoad || expMd || flush;
      expAccept = id_valid && id_is_muldiv && !expLoad && !expMd && !flush;
   end

   always @(posedge clk) begin
      if (rst) begin
         busyLeft <= 0;
         mLoadCnt <= 0;
         mMdCnt   <= 0;
      end else begin
         if (expAccept)         busyLeft <= LAT;
         else if (busyLeft > 0) busyLeft <= busyLeft - 1;
         if (expLoad) mLoadCnt <= mLoadCnt + 1;
         if (expMd)   mMdCnt   <= mMdCnt + 1;
      end
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      chk("stall",       32'(stall),       32'(expStall));
      chk("bubble",      32'(bubble),      32'(expBubble));
      chk("muldiv_busy", 32'(muldiv_busy), 32'(busyLeft > 0));
      if (!flush) begin
         chk("fwd_rs", 32'(fwd_rs), 32'(expFwdRs));
         chk("fwd_rt", 32'(fwd_rt), 32'(expFwdRt));
      end
`ifdef HAZARD_PERF_CNT_EN
      chk("stall_load_cnt",   stall_load_cnt,   32'(mLoadCnt));
      chk("stall_muldiv_cnt", stall_muldiv_cnt, 32'(mMdCnt));
`endif
   end

   // ---------------- directed stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic atNeg();
      @(negedge clk);
      #1;
   endtask

   task automatic clearIn();
      id_valid = 0; id_rs = 0; id_rt = 0; id_use_rs = 0; id_use_rt = 0;
      id_is_muldiv = 0; id_reads_hilo = 0; flush = 0;
      hist1 = 0; hist2 = 0; hist3 = 0;
   endtask

   initial begin
      rst = 1;
      clearIn();
      tick();
      atNeg();
      chk("rst_stall",  32'(stall),       0);
      chk("rst_bubble", 32'(bubble),      0);
      chk("rst_fwd_rs", 32'(fwd_rs),      0);
      chk("rst_fwd_rt", 32'(fwd_rt),      0);
      chk("rst_busy",   32'(muldiv_busy), 0);
      rst = 0;
      tick();

      // load-use, then MEM forward
      id_valid = 1; id_rs = 5'd8; id_use_rs = 1; hist1 = {1'b1, 5'd8};
      atNeg();
      chk("lu_stall",  32'(stall),  1);
      chk("lu_bubble", 32'(bubble), 1);
      tick();
      hist1 = 0; hist2 = {1'b1, 5'd8};
      atNeg();
      chk("lu_mem_stall", 32'(stall),  0);
      chk("lu_mem_fwd",   32'(fwd_rs), 2'b10);
      tick();

      // nearest producer wins
      clearIn();
      id_valid = 1; id_rt = 5'd9; id_use_rt = 1;
      hist1 = {1'b0, 5'd9}; hist2 = {1'b0, 5'd9}; hist3 = {1'b0, 5'd9};
      atNeg();
      chk("pri_ex",    32'(fwd_rt), 2'b01);
      chk("pri_stall", 32'(stall),  0);
      tick();
      hist1 = 0;
      atNeg();
      chk("pri_mem", 32'(fwd_rt), 2'b10);
      tick();
      hist2 = 0;
      atNeg();
      chk("pri_wb", 32'(fwd_rt), 2'b11);
      tick();
      id_valid = 0;
      atNeg();
      chk("novalid_fwd", 32'(fwd_rt), 2'b00);
      tick();

      // register 0 never matches
      clearIn();
      id_valid = 1; id_rs = 0; id_use_rs = 1;
      atNeg();
      chk("r0_fwd", 32'(fwd_rs), 2'b00);
      tick();
      hist1 = {1'b1, 5'd0};
      atNeg();
      chk("r0_load_stall", 32'(stall), 0);
      tick();
      // both operands from EX
      clearIn();
      id_valid = 1; id_rs = 5'd3; id_rt = 5'd3; id_use_rs = 1; id_use_rt = 1;
      hist1 = {1'b0, 5'd3};
      atNeg();
      chk("both_rs", 32'(fwd_rs), 2'b01);
      chk("both_rt", 32'(fwd_rt), 2'b01);
      tick();

      // div then mflo (with an overlapping load-use on cycle 1)
      clearIn();
      id_valid = 1; id_is_muldiv = 1;
      atNeg();
      chk("div_c0_busy", 32'(muldiv_busy), 0);
      tick();
      id_is_muldiv = 0; id_reads_hilo = 1;
      id_rs = 5'd5; id_use_rs = 1; hist1 = {1'b1, 5'd5};
      atNeg();
      chk("mflo_c1_stall", 32'(stall),       1);
      chk("mflo_c1_busy",  32'(muldiv_busy), 1);
      tick();
      hist1 = 0; id_use_rs = 0;
      for (int c = 2; c <= 3; c++) begin
         atNeg();
         chk("mflo_stall", 32'(stall), 1);
         tick();
      end
      atNeg();
      chk("mflo_c4_stall", 32'(stall),       0);
      chk("mflo_c4_busy",  32'(muldiv_busy), 1);
      tick();
      clearIn();
      atNeg();
      chk("mflo_c5_busy", 32'(muldiv_busy), 0);
      tick();

      // div then div: no idle gap, flush does not abort in-flight op
      id_valid = 1; id_is_muldiv = 1;
      tick();
      for (int c = 1; c <= 4; c++) begin
         atNeg();
         chk("div2_stall", 32'(stall), (c < 4) ? 1 : 0);
         tick();
      end
      id_valid = 0; id_is_muldiv = 0;
      atNeg();
      chk("div2_c5_busy", 32'(muldiv_busy), 1);
      tick();
      id_valid = 1; id_is_muldiv = 1; flush = 1;
      atNeg();
      chk("div2_flush_stall",  32'(stall),  0);
      chk("div2_flush_bubble", 32'(bubble), 1);
      tick();
      clearIn();
      tick();
      atNeg();
      chk("div2_c8_busy", 32'(muldiv_busy), 1);
      tick();
      atNeg();
      chk("div2_c9_busy", 32'(muldiv_busy), 0);
      tick();

      // flush over a load-use and an acceptable div
      clearIn();
      id_valid = 1; id_rs = 5'd8; id_use_rs = 1; hist1 = {1'b1, 5'd8};
      flush = 1;
      atNeg();
      chk("fl_stall",  32'(stall),  0);
      chk("fl_bubble", 32'(bubble), 1);
      tick();
      clearIn();
      id_valid = 1; id_is_muldiv = 1; flush = 1;
      tick();
      clearIn();
      atNeg();
      chk("fl_div_busy", 32'(muldiv_busy), 0);
      tick();

      // reset in the middle of BUSY
      id_valid = 1; id_is_muldiv = 1;
      tick();
      clearIn();
      atNeg();
      chk("rb_c1_busy", 32'(muldiv_busy), 1);
      tick();
      rst = 1;
      tick();
      rst = 0;
      id_valid = 1; id_reads_hilo = 1;
      atNeg();
      chk("rb_busy",  32'(muldiv_busy), 0);
      chk("rb_stall", 32'(stall),       0);
`ifdef HAZARD_PERF_CNT_EN
      chk("rb_load_cnt", stall_load_cnt,   0);
      chk("rb_md_cnt",   stall_muldiv_cnt, 0);
`endif
      tick();
      clearIn();
      tick();
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
      $finish;
   end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Hazard and forwarding controller for the 5-stage MIPS pipeline. It reads the 3-deep destination-register history from the pipeline scoreboard: -1 = EX, -2 = MEM, -3 = WB. Each history entry is 6 bits, where bit5 = load flag and bits[4:0] = destination register.
- Produces the decode-stage stall, the EX bubble-inject, and per-operand forwarding selects.
- Owns a multi-cycle mult/div busy FSM.
- Sits between ID decode and the scoreboard and issue/bypass muxes.

Parameters:
MULDIV_LAT, 4, cycles a mult/div occupies the HI/LO unit (legal range 2..15)
CNT_W, 32, width of performance counters (optional feature only)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
id_valid  in  1  ID holds a valid instruction
id_rs  in  5  source register rs
id_rt  in  5  source register rt
id_use_rs  in  1  instruction reads rs
id_use_rt  in  1  instruction reads rt
id_is_muldiv  in  1  instruction is mult/multu/div/divu
id_reads_hilo  in  1  instruction is mfhi/mflo
flush  in  1  branch/exception flush of IF/ID
hist1  in  6  scoreboard entry -1 (EX): {is_load, reg}
hist2  in  6  scoreboard entry -2 (MEM)
hist3  in  6  scoreboard entry -3 (WB)
stall  out  1  hold PC and IF/ID this cycle
bubble  out  1  inject NOP into EX (scoreboard receives {0,5'd0})
fwd_rs  out  2  rs operand select: 00 regfile, 01 EX, 10 MEM, 11 WB
fwd_rt  out  2  rt operand select, same encoding
muldiv_busy  out  1  HI/LO unit occupied

Behaviour:
- All matches ignore reg 0: an entry matches only if its reg is nonzero and equals the source register, and the corresponding id_use_* is 1.
- Forward select, combinational:
  - Nearest match wins, priority EX > MEM > WB.
  - If id_valid=0, fwd_* = 00.
- Load-use hazard (combinational): id_valid, a used source matches hist1, and hist1[5]=1 → stall=1, bubble=1 for that cycle.
  - Next cycle the load sits in MEM (hist2). That is forwarded with select 10; no second stall.
  - A load matching in hist2 or hist3 never stalls.
- Mult/div FSM, states IDLE and BUSY, with a 4-bit down-counter cnt:
  - IDLE → BUSY when id_is_muldiv & id_valid & ~stall & ~flush; cnt loads MULDIV_LAT-1.
  - BUSY: cnt decrements each cycle. When cnt==0, return to IDLE that cycle edge.
  - muldiv_busy = (state==BUSY).
- In BUSY, id_valid & (id_is_muldiv | id_reads_hilo) → stall=1, bubble=1.
  - On the cycle the FSM returns to IDLE, stall deasserts. A waiting muldiv is accepted on the same edge, reloading the counter: back-to-back operations.
- Simultaneous load-use and muldiv stall: a single stall; both conditions OR'd.
- flush:
  - Forces stall=0 and bubble=1 that cycle; forwarding outputs are don't-care.
  - An instruction in ID is not accepted into the FSM.
  - An in-flight BUSY operation continues to completion, since it is already issued.
- rst (synchronous): state=IDLE, cnt=0. With id_valid=0, every output is 0: stall=0, bubble=0, fwd_rs=00, fwd_rt=00, muldiv_busy=0.
  - Reset asserted mid-BUSY aborts the operation at that edge.
- stall and bubble are always asserted together except during flush.
- Latency: all decisions are same-cycle combinational from inputs plus registered FSM state. There is no combinational path from stall back into the FSM inputs other than the accept qualifier.

Optional Feature:
HAZARD_PERF_CNT_EN
- Defined: adds output ports stall_load_cnt[CNT_W-1:0] and stall_muldiv_cnt[CNT_W-1:0].
  - Each counter increments on every cycle its stall cause is active.
  - If both causes are active, both increment.
  - Counters wrap at 2^CNT_W, are cleared by rst, and are unaffected by flush.
- Undefined: no counter ports or logic; all other behaviour identical.

Decomposition:
- Shared package mycpu_pkg holds:
  - FWD_REGFILE/FWD_EX/FWD_MEM/FWD_WB 2-bit constants
  - hist entry field positions (HIST_LOAD_BIT=5, HIST_REG_MSB=4)
  - muldiv FSM state enum
- One natural sub-module, fwd_sel: pure priority match of one source register against three history entries, instantiated twice (rs, rt).

Test Plan:
- hist1={1,5'd8}, id_rs=8, id_use_rs=1, id_valid=1 → stall=1, bubble=1. Next cycle hist2={1,8} → stall=0, fwd_rs=10.
- hist1={0,5'd9}, hist2={0,9}, hist3={0,9}, id_rt=9, id_use_rt=1 → fwd_rt=01, stall=0. With hist1 reg changed to 0 → fwd_rt=10.
- id_rs=0, all hist regs 0, id_use_rs=1 → fwd_rs=00, no stall. Load with reg 0 in hist1 → no stall.
- MULDIV_LAT=4: issue div at cycle 0, then mflo at cycle 1 → stall=1 on cycles 1–3, accepted cycle 4. A second div queued behind → busy resumes with no idle gap.
- flush asserted with load-use condition present → stall=0, bubble=1, FSM unchanged. With an accepted-candidate muldiv → muldiv_busy stays 0.
- rst asserted at cycle 2 of BUSY → next cycle muldiv_busy=0, stall=0. With HAZARD_PERF_CNT_EN defined, both counters read 0.
